// File: rtl/data_mem_responder.sv
// Load/store responder with an internal word RAM, programmable wait states and
// byte/half/word lanes. Define MISALIGN_TRAP_EN to flag misaligned half/word accesses.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, uns_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            enter_resp;

  // NOTE: RAM contents are deliberately not reset; only the control path is.
  logic [31:0]     mem_q [WORDS];

  // Upper address bits alias away.
  logic            unused_addr;
  assign unused_addr = ^req_addr[15:AW];

  // With zero wait states the access happens on the accepting edge, so the
  // live request is used in IDLE and the latched copy afterwards.
  logic            idle;
  logic            cur_we, cur_uns;
  logic [AW-1:0]   cur_addr;
  logic [1:0]      cur_size;
  logic [31:0]     cur_wdata;
  logic [DEPTH_LOG2-1:0] cur_idx;

  assign idle      = (state_q == S_IDLE);
  assign cur_we    = idle ? req_we           : we_q;
  assign cur_uns   = idle ? req_unsigned     : uns_q;
  assign cur_addr  = idle ? req_addr[AW-1:0] : addr_q;
  assign cur_size  = idle ? req_size         : size_q;
  assign cur_wdata = idle ? req_wdata        : wdata_q;
  assign cur_idx   = cur_addr[AW-1:2];

  logic mis;
`ifdef MISALIGN_TRAP_EN
  assign mis = ((cur_size == 2'b01) && cur_addr[0]) ||
               (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  logic [31:0] rd_word, load_ext, wlane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [3:0]  be;

  assign rd_word = mem_q[cur_idx];
  assign rd_byte = 8'(rd_word >> {cur_addr[1:0], 3'b000});
  assign rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    load_ext = rd_word;
    be       = 4'hF;
    wlane    = cur_wdata;
    case (cur_size)
      2'b00: begin
        load_ext = {{24{~cur_uns & rd_byte[7]}}, rd_byte};
        be       = 4'b0001 << cur_addr[1:0];
        wlane    = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        load_ext = {{16{~cur_uns & rd_half[15]}}, rd_half};
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d    = S_RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (cur_we || mis) ? 32'h0 : load_ext;
      err_d   = mis;
    end else if (state_q == S_RESP && resp_ready) begin
      err_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (idle && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[AW-1:0];
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  // A store still in flight when reset arrives must not reach the array.
  logic commit;
  assign commit = enter_resp && cur_we && !mis && !reset;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[cur_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready  = idle;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps plus randomized
// traffic against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH_LOG2  = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int BYTES       = 4 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int passed = 0;

  logic [7:0] ref_mem [BYTES];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Reference model: memory as a flat byte array indexed by the aliased address.
  function automatic logic model_mis(input logic [15:0] addr, input logic [1:0] size);
`ifdef MISALIGN_TRAP_EN
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return addr[1:0] != 2'd0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [15:0] addr, input logic [1:0] size,
                                             input logic uns);
    int n    = nbytes(size);
    int base = (int'(addr) % BYTES) / n * n;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [15:0] addr, input logic [1:0] size, input logic [31:0] wd);
    int n    = nbytes(size);
    int base = (int'(addr) % BYTES) / n * n;
    for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
  endtask

  // One full transaction; hold = cycles resp_ready stays low while in RESP.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd, input int hold);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat;
    exp_err = model_mis(addr, size);
    exp_rd  = (we || exp_err) ? 32'h0 : model_load(addr, size, uns);
    if (we && !exp_err) model_store(addr, size, wd);

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    check("rdata", resp_rdata, exp_rd);
    check("err", 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("valid_cleared", 32'(resp_valid), 32'd0);
    check("err_cleared", 32'(resp_err), 32'd0);
  endtask

  task automatic load_expect(input string tag, input logic [15:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] exp);
    check(tag, model_load(addr, size, uns), exp);
    txn(1'b0, addr, size, uns, 32'h0, 0);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b0;

    // Initialise words 0x00..0x43 so every later load has known contents.
    for (int w = 0; w < 17; w++)
      txn(1'b1, 16'(4 * w), 2'd2, 1'b0, (w == 16) ? 32'h1111_1111 : (32'h0101_0101 * w) ^ 32'hA5C3_0F96, 0);

    txn(1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 0);
    load_expect("word_0x10", 16'h0010, 2'd2, 1'b0, 32'hDEAD_BEEF);

    txn(1'b1, 16'h0013, 2'd0, 1'b0, 32'h0000_0080, 0);
    load_expect("byte_s", 16'h0013, 2'd0, 1'b0, 32'hFFFF_FF80);
    load_expect("byte_u", 16'h0013, 2'd0, 1'b1, 32'h0000_0080);
    load_expect("word_after_byte", 16'h0010, 2'd2, 1'b0, 32'h80AD_BEEF);

    txn(1'b1, 16'h0022, 2'd1, 1'b0, 32'h0000_1234, 0);
    load_expect("half_hi", 16'h0022, 2'd1, 1'b0, 32'h0000_1234);
    txn(1'b0, 16'h0020, 2'd1, 1'b0, 32'h0, 0);

    // Back-pressure: five cycles in RESP with resp_ready low.
    txn(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, 5);

    // Reset during WAIT of a store: the store must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_size = 2'd2;
    req_wdata = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("in_wait_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_rdata", resp_rdata, 32'h0);
    check("midrst_err", 32'(resp_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    load_expect("dropped_store", 16'h0040, 2'd2, 1'b0, 32'h1111_1111);

    // Misaligned word store: trapped with the macro, lane rules without it.
    txn(1'b1, 16'h0041, 2'd2, 1'b0, 32'hCAFE_F00D, 0);
`ifdef MISALIGN_TRAP_EN
    load_expect("mis_unchanged", 16'h0040, 2'd2, 1'b0, 32'h1111_1111);
`else
    load_expect("mis_written", 16'h0040, 2'd2, 1'b0, 32'hCAFE_F00D);
`endif
    txn(1'b0, 16'h0023, 2'd1, 1'b1, 32'h0, 0);

    // Randomized traffic over the initialised region with aliased upper bits.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] a;
      logic [1:0]  sz;
      a  = 16'($urandom) & 16'hF03F;
      sz = 2'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake, inserts programmable wait states, performs byte/half/word writes or sign/zero-extended reads, and returns a response over a second valid/ready handshake.
- Sits between the processor datapath (initiator) and a synthesizable word-organised RAM array internal to this block.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words; uses req_addr[DEPTH_LOG2+1:2].
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  initiator has a request
- req_ready  output  1  responder can accept a request
- req_we  input  1  1=store, 0=load
- req_addr  input  16  byte address
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  response available
- resp_ready  input  1  initiator accepts response
- resp_rdata  output  32  load result; 0 for stores
- resp_err  output  1  misaligned-access flag; only driven when MISALIGN_TRAP_EN is defined, else tied 0

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- IDLE: req_ready=1. Handshake on req_valid&&req_ready at edge N latches we/addr/size/unsigned/wdata.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: req_ready=0. Counter decrements each cycle. At counter==0 go to RESP.
- Latency: resp_valid first high in cycle N+1+WAIT_CYCLES.
- Store commit and load sampling occur on the edge that enters RESP.
  - Stores write only the selected byte lanes.
  - Loads capture extended data into resp_rdata on that edge.
  - A load following a store to the same word returns the new data.
- RESP: resp_valid=1. resp_rdata/resp_err held stable until resp_valid&&resp_ready. On that edge go to IDLE and clear resp_valid.
  - req_ready returns to 1 the cycle after the response handshake. No request/response overlap.
- Lane selection:
  - Byte uses addr[1:0].
  - Half uses addr[1] (addr[0] ignored).
  - Word ignores addr[1:0].
- Load extension: byte/half sign-extended unless req_unsigned=1. Word loads ignore req_unsigned.
- Addressing: req_addr bits above DEPTH_LOG2+1 are ignored; addresses alias modulo 4*2^DEPTH_LOG2.
- req_valid while req_ready=0 is ignored; the initiator must hold it.
- Reset asserted mid-transaction: FSM returns to IDLE immediately. A store not yet committed is dropped. Any response is discarded.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1 or word with addr[1:0]!=0 is flagged.
  - No RAM write occurs.
  - Response still follows normal latency with resp_rdata=0 and resp_err=1.
  - resp_err clears on the response handshake.
- Undefined: resp_err is constant 0 and misaligned accesses use the lane rules above.

Test Plan:
- Reset, then store word 0xDEADBEEF to 0x0010, then load word from 0x0010 -> resp_rdata=0xDEADBEEF; resp_valid first high exactly 3 cycles after acceptance (WAIT_CYCLES=2).
- Store byte 0x80 to 0x0013, then load byte signed from 0x0013 -> 0xFFFFFF80. Load byte unsigned from 0x0013 -> 0x00000080. Load word from 0x0010 -> 0x80ADBEEF.
- Store half 0x1234 to 0x0022, then load half signed from 0x0022 -> 0x00001234. Load half signed from 0x0020 returns the lower lane unchanged from prior contents.
- Hold resp_ready=0 for 5 cycles during RESP -> resp_valid and resp_rdata stable, req_ready=0 throughout. Raise resp_ready -> req_ready=1 the next cycle.
- Assert reset during WAIT of a store to 0x0040 (prior value 0x11111111) -> outputs return to reset values. A later load of 0x0040 returns 0x11111111.
- With MISALIGN_TRAP_EN: store word to 0x0041 -> resp_err=1, resp_rdata=0, RAM unchanged. Without the macro: same store writes word index 0x10 and resp_err=0.
